// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns, output-state enum and the pattern decoder.
// SEG7_BLANK_EN: when defined, the all-off pattern decodes as a legal blank digit.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [0:0] {EMPTY, FULL} state_e;

  // Returns {err, nibble}; unknown patterns give nibble 0 with err set.
  function automatic logic [4:0] seg7_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      SEG_0:     r = 5'h00;
      SEG_1:     r = 5'h01;
      SEG_2:     r = 5'h02;
      SEG_3:     r = 5'h03;
      SEG_4:     r = 5'h04;
      SEG_5:     r = 5'h05;
      SEG_6:     r = 5'h06;
      SEG_7:     r = 5'h07;
      SEG_8:     r = 5'h08;
      SEG_9:     r = 5'h09;
      SEG_A:     r = 5'h0A;
      SEG_B:     r = 5'h0B;
      SEG_C:     r = 5'h0C;
      SEG_D:     r = 5'h0D;
      SEG_E:     r = 5'h0E;
      SEG_F:     r = 5'h0F;
`ifdef SEG7_BLANK_EN
      SEG_BLANK: r = 5'h00;
`endif
      default:   r = 5'h10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// Display-bus sampling inputs and decoded-frame valid/ready output of seg7_capture.
// SEG7_BLANK_EN adds the frm_blank field.
interface seg7_capture_if #(parameter int NUM_DIGITS = 4);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    smp_en;
  logic [4*NUM_DIGITS-1:0] frm_data;
  logic [NUM_DIGITS-1:0]   frm_err;
  logic                    frm_valid;
  logic                    frm_ready;
  logic                    ovf;
`ifdef SEG7_BLANK_EN
  logic [NUM_DIGITS-1:0]   frm_blank;
`endif

  modport master (
    output seg_n, dig_sel, smp_en, frm_ready,
    input  frm_data, frm_err, frm_valid, ovf
`ifdef SEG7_BLANK_EN
    , input frm_blank
`endif
  );

  modport slave (
    input  seg_n, dig_sel, smp_en, frm_ready,
    output frm_data, frm_err, frm_valid, ovf
`ifdef SEG7_BLANK_EN
    , output frm_blank
`endif
  );
endinterface

// File: rtl/seg7_digit_lock.sv
// Debounce/lock for one digit: counts identical consecutive samples and freezes the decode.
// SEG7_BLANK_EN adds the blank output.
module seg7_digit_lock
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       smp,
  input  logic [6:0] seg_n,
  output logic       done,
  output logic [3:0] nib,
  output logic       err
`ifdef SEG7_BLANK_EN
  , output logic     blank
`endif
);
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

  logic [6:0]       last;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock, locking;
  logic [3:0]       nib_q;
  logic             err_q;
  logic [4:0]       dec;

  assign dec = seg7_decode(seg_n);

  always_comb begin
    cnt_nxt = CNT_W'(1);
    if (seg_n == last)
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  end

  // done includes the locking sample itself so the frame can load on the same edge
  assign locking = smp && !lock && (cnt_nxt == CNT_MAX);
  assign done    = lock || locking;
  assign nib     = lock ? nib_q : dec[3:0];
  assign err     = lock ? err_q : dec[4];

`ifdef SEG7_BLANK_EN
  logic blank_q;
  assign blank = lock ? blank_q : (seg_n == SEG_BLANK);
  always_ff @(posedge clk) begin
    if (rst)          blank_q <= 1'b0;
    else if (locking) blank_q <= (seg_n == SEG_BLANK);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= SEG_BLANK;
      cnt   <= '0;
      lock  <= 1'b0;
      nib_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (smp && !lock) begin
        last <= seg_n;
        cnt  <= cnt_nxt;
      end
      if (locking) begin
        lock  <= 1'b1;
        nib_q <= dec[3:0];
        err_q <= dec[4];
      end
      if (clr) begin
        cnt  <= '0;
        lock <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed active-low 7-segment bus into decoded multi-digit frames (valid/ready).
// SEG7_BLANK_EN: treat 7'h7F as a legal blank digit and drive frm_blank.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input logic           clk,
  input logic           rst,
  seg7_capture_if.slave bus
);
  localparam logic [0:0] S_EMPTY = EMPTY;
  localparam logic [0:0] S_FULL  = FULL;

  logic                    smp_cycle, complete, load;
  logic [NUM_DIGITS-1:0]   done;
  logic [4*NUM_DIGITS-1:0] cand_data, data_q;
  logic [NUM_DIGITS-1:0]   cand_err, err_q;
  logic [0:0]              state;
  logic                    ovf_q;

  // Exactly one digit selected while the strobe is high; anything else is ignored
  assign smp_cycle = bus.smp_en && (bus.dig_sel != '0) &&
                     ((bus.dig_sel & (bus.dig_sel - NUM_DIGITS'(1))) == '0);

`ifdef SEG7_BLANK_EN
  logic [NUM_DIGITS-1:0] cand_blank, blank_q;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_digit_lock #(.STABLE_CNT(STABLE_CNT)) u_lock (
      .clk   (clk),
      .rst   (rst),
      .clr   (complete),
      .smp   (smp_cycle && bus.dig_sel[g]),
      .seg_n (bus.seg_n),
      .done  (done[g]),
      .nib   (cand_data[4*g +: 4]),
      .err   (cand_err[g])
`ifdef SEG7_BLANK_EN
      , .blank (cand_blank[g])
`endif
    );
  end

  assign complete = &done;
  assign load     = complete && ((state == S_EMPTY) || bus.frm_ready);

  // A completion while the held frame is not being taken is dropped and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_EMPTY;
      data_q <= '0;
      err_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (load) begin
        state  <= S_FULL;
        data_q <= cand_data;
        err_q  <= cand_err;
      end else if ((state == S_FULL) && bus.frm_ready) begin
        state <= S_EMPTY;
      end
      if (complete && !load)
        ovf_q <= 1'b1;
    end
  end

`ifdef SEG7_BLANK_EN
  always_ff @(posedge clk) begin
    if (rst)       blank_q <= '0;
    else if (load) blank_q <= cand_blank;
  end
  assign bus.frm_blank = blank_q;
`endif

  assign bus.frm_data  = data_q;
  assign bus.frm_err   = err_q;
  assign bus.frm_valid = (state == S_FULL);
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Randomised self-checking bench for seg7_capture against a history-based reference model.
// Honours SEG7_BLANK_EN the same way as the design.
module tb_seg7_capture;
  localparam int ND = 4;
  localparam int SC = 3;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  seg7_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: per-digit sample history since the last frame, locked value, output register
  logic [6:0]      hist [ND][$];
  logic [ND-1:0]   mLock;
  logic [6:0]      mPat [ND];
  logic            mValid;
  logic            mOvf;
  logic [4*ND-1:0] mData;
  logic [ND-1:0]   mErr;
  logic [ND-1:0]   mBlank;

  // {blank, err, nibble}
  function automatic logic [5:0] refDecode(input logic [6:0] p);
    for (int k = 0; k < 16; k++)
      if (tbl[k] == p) return {2'b00, 4'(k)};
`ifdef SEG7_BLANK_EN
    if (p == 7'h7F) return 6'b100000;
`endif
    return 6'b010000;
  endfunction

  task automatic modelStep(input logic r, input logic smp, input logic [ND-1:0] sel,
                           input logic [6:0] seg, input logic rdy);
    logic            complete;
    logic [4*ND-1:0] fData;
    logic [ND-1:0]   fErr, fBlank;
    logic [5:0]      d;
    int              n;
    bit              same;
    if (r) begin
      for (int i = 0; i < ND; i++) hist[i].delete();
      mLock = '0; mValid = 0; mOvf = 0; mData = '0; mErr = '0; mBlank = '0;
      return;
    end
    if (smp && $countones(sel) == 1) begin
      for (int i = 0; i < ND; i++) begin
        if (sel[i] && !mLock[i]) begin
          hist[i].push_back(seg);
          n = hist[i].size();
          if (n >= SC) begin
            same = 1;
            for (int k = 1; k <= SC; k++)
              if (hist[i][n-k] != seg) same = 0;
            if (same) begin
              mLock[i] = 1'b1;
              mPat[i]  = seg;
            end
          end
        end
      end
    end
    complete = &mLock;
    if (complete) begin
      for (int i = 0; i < ND; i++) begin
        d = refDecode(mPat[i]);
        fData[4*i +: 4] = d[3:0];
        fErr[i]         = d[4];
        fBlank[i]       = d[5];
        hist[i].delete();
      end
      mLock = '0;
      if (!mValid || rdy) begin
        mData = fData; mErr = fErr; mBlank = fBlank; mValid = 1;
      end else begin
        mOvf = 1;
      end
    end else if (mValid && rdy) begin
      mValid = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, check all outputs just after the edge
  task automatic applyStimulus(input logic r, input logic smp, input logic [ND-1:0] sel,
                               input logic [6:0] seg, input logic rdy);
    rst           = r;
    bus.smp_en    = smp;
    bus.dig_sel   = sel;
    bus.seg_n     = seg;
    bus.frm_ready = rdy;
    modelStep(r, smp, sel, seg, rdy);
    @(posedge clk);
    #1;
    checkOutput("frm_valid", 32'(bus.frm_valid), 32'(mValid));
    checkOutput("frm_data", 32'(bus.frm_data), 32'(mData));
    checkOutput("frm_err", 32'(bus.frm_err), 32'(mErr));
    checkOutput("ovf", 32'(bus.ovf), 32'(mOvf));
`ifdef SEG7_BLANK_EN
    checkOutput("frm_blank", 32'(bus.frm_blank), 32'(mBlank));
`endif
  endtask

  task automatic sendDigit(input int dg, input logic [6:0] p, input logic rdyLast);
    for (int k = 0; k < SC; k++)
      applyStimulus(0, 1, ND'(1) << dg, p, (k == SC-1) ? rdyLast : 1'b0);
  endtask

  task automatic sendFrame(input logic [27:0] pats, input logic rdyLast);
    for (int dg = 0; dg < ND; dg++)
      sendDigit(dg, pats[7*dg +: 7], (dg == ND-1) ? rdyLast : 1'b0);
  endtask

  logic [6:0] fav [ND];
  int         dsel;
  logic [ND-1:0] sel;
  logic [6:0]    seg;

  initial begin
    tests = 0;
    fails = 0;
    mLock = '0;
    applyStimulus(1, 0, '0, 7'h7F, 0);
    applyStimulus(1, 0, '0, 7'h7F, 0);

    // Digits 0..3 = 0,1,2,3
    sendFrame({7'h30, 7'h24, 7'h79, 7'h40}, 0);
    applyStimulus(0, 0, '0, 7'h00, 1);

    // Alternating digit 2 must not lock until three identical samples
    sendDigit(0, 7'h40, 0);
    sendDigit(1, 7'h79, 0);
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 4'b0100, k[0] ? 7'h30 : 7'h24, 0);
    sendDigit(3, 7'h19, 0);
    sendDigit(2, 7'h30, 0);
    applyStimulus(0, 0, '0, 7'h00, 1);

    // Undecodable pattern and blank pattern
    sendFrame({7'h7F, 7'h40, 7'h55, 7'h12}, 1);
    applyStimulus(0, 0, '0, 7'h00, 1);

    // Overflow, then handshake coinciding with a new completion
    sendFrame({7'h08, 7'h03, 7'h46, 7'h21}, 0);
    sendFrame({7'h06, 7'h0E, 7'h00, 7'h10}, 0);
    sendFrame({7'h78, 7'h02, 7'h12, 7'h19}, 1);
    applyStimulus(0, 0, '0, 7'h00, 1);

    // Multi-hot select and disabled strobe are ignored
    sendDigit(0, 7'h40, 0);
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 4'b0110, tbl[k], 0);
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, 4'b0010, tbl[k], 0);
    sendFrame({7'h30, 7'h24, 7'h79, 7'h40}, 0);
    applyStimulus(0, 0, '0, 7'h00, 1);

    // Reset with three digits locked
    sendDigit(0, 7'h40, 0);
    sendDigit(1, 7'h40, 0);
    sendDigit(2, 7'h40, 0);
    applyStimulus(1, 0, '0, 7'h00, 0);
    sendDigit(3, 7'h40, 0);
    sendFrame({7'h79, 7'h79, 7'h79, 7'h79}, 0);
    applyStimulus(0, 0, '0, 7'h00, 1);

    // Random traffic biased toward each digit's favourite pattern
    for (int i = 0; i < ND; i++) fav[i] = tbl[$urandom_range(0, 15)];
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 40) == 0) fav[$urandom_range(0, ND-1)] = tbl[$urandom_range(0, 15)];
      dsel = $urandom_range(0, ND-1);
      case ($urandom_range(0, 9))
        0:       sel = '0;
        1:       sel = ND'($urandom);
        default: sel = ND'(1) << dsel;
      endcase
      if ($urandom_range(0, 3) != 0)      seg = fav[dsel];
      else if ($urandom_range(0, 5) == 0) seg = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h55;
      else                                seg = tbl[$urandom_range(0, 15)];
      applyStimulus($urandom_range(0, 300) == 0, $urandom_range(0, 9) != 0, sel, seg,
                    $urandom_range(0, 1) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
